approx_prod_acc: RTL and testbench
==================================

# approx_prod_acc

Accumulator stage placed directly downstream of the 16x16 approximate unsigned multipliers (mul16u_* family). It accepts a stream of 32-bit approximate products over a valid/ready handshake. It sums each group of LEN products using only product bits [31:DROP]; the multipliers' low bits are zero or insignificant. It then presents one buffered dot-product result per group on a second valid/ready handshake.

## Interface
- LEN, 16: products per group; integer ≥ 1.
- DROP, 24: product LSBs discarded before accumulation; 0..31.
- CW, $clog2(LEN) (derived, localparam): counter/growth width; 0 when LEN=1.
- SW, 32-DROP+CW (derived, localparam): result width; default 12.

Ports:
- CLK  in  1  sole clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  P holds a valid product.
- IN_READY  out  1  block accepts P this cycle.
- P  in  32  approximate product from the upstream multiplier.
- CLR  in  1  synchronous abort of the group in progress.
- OUT_VALID  out  1  S holds a completed group sum.
- OUT_READY  in  1  consumer takes S this cycle.
- S  out  SW  sum of P[31:DROP] over the last completed group.
- GRP_CNT  out  CW (min 1)  number of products accepted in the current group.

## Operation
- Beat: IN_VALID & IN_READY at a rising CLK edge. Each beat adds the zero-extended P[31:DROP] to ACC (SW bits). ACC is sized so it never overflows, and no saturation logic exists.
- Group state: the counter cnt runs 0..LEN-1. States: EMPTY (cnt=0), ACCUM (0<cnt<LEN). An independent result-buffer flag FULL (=OUT_VALID) is kept alongside.
- Non-last beat (cnt<LEN-1): ACC ← ACC+P[31:DROP], cnt ← cnt+1.
- Last beat (cnt=LEN-1): S ← ACC+P[31:DROP], OUT_VALID ← 1, ACC ← 0, cnt ← 0. When LEN=1, every beat is a last beat.
- IN_READY = !(cnt==LEN-1 && OUT_VALID && !OUT_READY). This is combinational in OUT_READY. Non-last beats are always accepted while a result is pending.
- Output: OUT_VALID & OUT_READY drains the buffer. If a last beat coincides with the drain, S is reloaded and OUT_VALID stays 1.
- S and OUT_VALID remain stable while OUT_VALID=1 and OUT_READY=0.
- CLR=1: ACC ← 0, cnt ← 0. The beat in the same cycle is discarded, although IN_READY still reflects the normal rule. S and OUT_VALID are unaffected, and a pending result survives CLR.
- P bits [DROP-1:0] never influence any output.

## Timing
- Reset (RST_N=0, async): ACC=0, cnt=0, S=0, OUT_VALID=0, GRP_CNT=0, IN_READY=1 (combinational from reset state). Deassertion takes effect at the next CLK edge.
- Reset mid-group or with a pending result: everything is lost and no partial result is emitted.
- Latency: S/OUT_VALID appear at the edge that accepts the last beat, so they are visible the cycle after it. Accumulation is single-cycle.
- Throughput: one product per cycle indefinitely when OUT_READY=1. A stall occurs only on a last beat with an undrained result.
- Outputs S, OUT_VALID and GRP_CNT are registered. IN_READY is the only combinational output.

## Test plan
- Full scale, LEN=16, DROP=24: 16 beats with P=0xFF000000 and OUT_READY=1 → S=0xFF0, OUT_VALID for 1 cycle, 16 cycles from first beat to result edge, no IN_READY drop.
- LSB masking: 4 beats each of P=0x01FFFFFF, 0x00FFFFFF, 0x80000000, 0x7F000000 (16 beats) → S=4·(1+0+128+127)=1024=0x400.
- Backpressure: group of P=0x01000000 (S=16) with OUT_READY=0, then the next group's 15 beats → all accepted, and IN_READY=0 at cnt=15. Raising OUT_READY → S=16 drained, 16th beat accepted the same cycle, and the next S appears correctly.
- CLR mid-group: 7 beats, then CLR with a concurrent beat, then 16 beats of 0x02000000 → only S=32 is emitted, and GRP_CNT=0 the cycle after CLR.
- Async reset with OUT_VALID=1 and cnt=9 → outputs go to 0 immediately without waiting for CLK. The next full group yields the correct sum.
- LEN=1, DROP=0: P=0xFFFFFFFF → S=0xFFFFFFFF on each beat, back-to-back, with OUT_READY=1.

Source files
------------

// File: rtl/approx_prod_acc.sv
// Group accumulator for approximate 16x16 products.
// Sums LEN truncated products, emits one buffered result per group.
module approx_prod_acc #(
    parameter int LEN  = 16,
    parameter int DROP = 24,
    localparam int CW  = $clog2(LEN),
    localparam int SW  = 32 - DROP + CW,
    localparam int GW  = (CW > 0) ? CW : 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [31:0]   P,
    input  logic          CLR,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [SW-1:0] S,
    output logic [GW-1:0] GRP_CNT
);

    localparam logic [GW-1:0] LAST_CNT = GW'(LEN - 1);

    logic [SW-1:0] acc_q, acc_d;
    logic [SW-1:0] s_q, s_d;
    logic [GW-1:0] cnt_q, cnt_d;
    logic          full_q, full_d;

    logic [SW-1:0] p_trunc;
    logic          last;
    logic          in_ready;
    logic          beat;

    // Only the significant product bits are ever summed.
    assign p_trunc = SW'(P[31:DROP]);

    // A last beat may only land when the result buffer is free or draining.
    always_comb begin
        last     = (cnt_q == LAST_CNT);
        in_ready = !(last && full_q && !OUT_READY);
        beat     = IN_VALID && in_ready;
    end

    // Next-state for accumulator, group counter and result buffer.
    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        s_d    = s_q;
        full_d = full_q;
        if (full_q && OUT_READY) begin
            full_d = 1'b0;
        end
        if (CLR) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (beat) begin
            if (last) begin
                s_d    = acc_q + p_trunc;
                full_d = 1'b1;
                acc_d  = '0;
                cnt_d  = '0;
            end else begin
                acc_d = acc_q + p_trunc;
                cnt_d = cnt_q + GW'(1);
            end
        end
    end

    // State registers; reset discards any partial or pending result.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            s_q    <= '0;
            full_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            s_q    <= s_d;
            full_q <= full_d;
        end
    end

    assign IN_READY  = in_ready;
    assign OUT_VALID = full_q;
    assign S         = s_q;
    assign GRP_CNT   = cnt_q;

endmodule

// File: tb/tb_approx_prod_acc.sv
// Bench for approx_prod_acc: LEN=16/DROP=24 and LEN=1/DROP=0.
// Expected sums queued at issue, popped by output monitors.
module tb_approx_prod_acc;

    logic        CLK;
    logic        RST_N;
    logic        in_valid, in_ready, clr, out_valid, out_ready;
    logic [31:0] p;
    logic [11:0] s;
    logic [3:0]  grp_cnt;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_p, b_s;
    logic [0:0]  b_grp_cnt;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [31:0] exp_q[$];
    logic [31:0] b_exp_q[$];

    approx_prod_acc #(.LEN(16), .DROP(24)) u_dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .P         (p),
        .CLR       (clr),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .S         (s),
        .GRP_CNT   (grp_cnt)
    );

    approx_prod_acc #(.LEN(1), .DROP(0)) u_dut1 (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (b_in_valid),
        .IN_READY  (b_in_ready),
        .P         (b_p),
        .CLR       (1'b0),
        .OUT_VALID (b_out_valid),
        .OUT_READY (b_out_ready),
        .S         (b_s),
        .GRP_CNT   (b_grp_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Monitor: every result handshake must match the next queued sum.
    always @(negedge CLK) begin
        if (RST_N && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL a_extra got=%h want=none", s);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if ({20'd0, s} !== e) begin
                    bad++;
                    $display("FAIL a_sum got=%h want=%h", s, e);
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (RST_N && b_out_valid && b_out_ready) begin
            total++;
            if (b_exp_q.size() == 0) begin
                bad++;
                $display("FAIL b_extra got=%h want=none", b_s);
            end else begin
                logic [31:0] e;
                e = b_exp_q.pop_front();
                if (b_s !== e) begin
                    bad++;
                    $display("FAIL b_sum got=%h want=%h", b_s, e);
                end
            end
        end
    end

    // One beat: hold valid until accepted, bounded wait.
    task automatic beat(input logic [31:0] v);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        p = v;
        for (int i = 0; i < 50; i++) begin
            #4;
            if (in_ready) begin
                ok = 1;
                break;
            end
            @(posedge CLK);
            #1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL beat_timeout got=stalled want=accepted");
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic grp(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) beat(v);
    endtask

    initial begin
        int c0;
        logic [31:0] lsb_v[4];
        logic [31:0] b_v[4];
        lsb_v = '{32'h01FFFFFF, 32'h00FFFFFF, 32'h80000000, 32'h7F000000};
        b_v   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF};

        RST_N = 1'b0;
        in_valid = 1'b0;
        p = '0;
        clr = 1'b0;
        out_ready = 1'b1;
        b_in_valid = 1'b0;
        b_p = '0;
        b_out_ready = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_s", {20'd0, s}, 32'd0);
        chk("rst_grp_cnt", {28'd0, grp_cnt}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // Full scale, no stalls, single-cycle result.
        exp_q.push_back(32'hFF0);
        c0 = cyc;
        grp(32'hFF000000, 16);
        chk("full_cycles", cyc - c0, 32'd16);
        chk("full_valid_on", {31'd0, out_valid}, 32'd1);
        @(posedge CLK);
        #1;
        chk("full_valid_off", {31'd0, out_valid}, 32'd0);

        // Low bits must be ignored.
        exp_q.push_back(32'h400);
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) beat(lsb_v[k]);
        @(posedge CLK);
        #1;

        // Backpressure on the last beat only.
        out_ready = 1'b0;
        exp_q.push_back(32'd16);
        grp(32'h01000000, 16);
        exp_q.push_back(32'd48);
        grp(32'h03000000, 15);
        in_valid = 1'b1;
        p = 32'h03000000;
        @(negedge CLK);
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("bp_grp_cnt", {28'd0, grp_cnt}, 32'd15);
        chk("bp_pending", {31'd0, out_valid}, 32'd1);
        chk("bp_s_hold", {20'd0, s}, 32'd16);
        @(posedge CLK);
        #1;
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_up", {31'd0, in_ready}, 32'd1);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        chk("bp_reload_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_grp_wrap", {28'd0, grp_cnt}, 32'd0);
        @(posedge CLK);
        #1;

        // Abort mid-group, beat during CLR discarded.
        grp(32'h05000000, 7);
        clr = 1'b1;
        in_valid = 1'b1;
        p = 32'h05000000;
        @(posedge CLK);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        chk("clr_grp_cnt", {28'd0, grp_cnt}, 32'd0);
        chk("clr_no_out", {31'd0, out_valid}, 32'd0);
        exp_q.push_back(32'd32);
        grp(32'h02000000, 16);
        @(posedge CLK);
        #1;

        // Async reset with a pending result and cnt=9.
        out_ready = 1'b0;
        grp(32'h01000000, 16);
        grp(32'h01000000, 9);
        chk("ar_pre_cnt", {28'd0, grp_cnt}, 32'd9);
        chk("ar_pre_valid", {31'd0, out_valid}, 32'd1);
        #1;
        RST_N = 1'b0;
        #1;
        chk("ar_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_cnt", {28'd0, grp_cnt}, 32'd0);
        chk("ar_s", {20'd0, s}, 32'd0);
        #1;
        RST_N = 1'b1;
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        exp_q.push_back(32'hA0);
        grp(32'h0A000000, 16);
        @(posedge CLK);
        #1;

        // LEN=1, DROP=0: every beat is a full-width result.
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 1'b1;
            b_p = b_v[i];
            b_exp_q.push_back(b_v[i]);
            #1;
            chk("b_in_ready", {31'd0, b_in_ready}, 32'd1);
            @(posedge CLK);
            #1;
        end
        b_in_valid = 1'b0;
        chk("b_grp_cnt", {31'd0, b_grp_cnt}, 32'd0);

        repeat (5) @(posedge CLK);
        #1;
        chk("a_queue_empty", exp_q.size(), 32'd0);
        chk("b_queue_empty", b_exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
